// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
// STOP2 keeps its encoding even when UART_TX_STOP2_EN is not defined.
package uart_tx_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } tx_state_e;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity over the latched payload.
// par_typ = PAR_ODD inverts the even-parity bit.
module uart_parity_calc
    import uart_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_DATA_WIDTH
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             par_bit
);

    assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: start / data / parity / stop around an external serializer.
// Define UART_TX_STOP2_EN for two stop bits (new data accepted only in the second).
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_valid,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  ser_done,
    input  logic                  s_data,
    output logic [DATA_WIDTH-1:0] data_reg,
    output logic                  ser_en,
    output logic                  tx_out,
    output logic                  busy
);

`ifdef UART_TX_STOP2_EN
    localparam tx_state_e LAST_STOP = STOP2;
`else
    localparam tx_state_e LAST_STOP = STOP;
`endif

    tx_state_e state;
    logic      par_en_r;
    logic      par_typ_r;
    logic      par_bit;
    logic      accept;

    uart_parity_calc #(
        .WIDTH (DATA_WIDTH)
    ) u_parity (
        .data    (data_reg),
        .par_typ (par_typ_r),
        .par_bit (par_bit)
    );

    // A new frame may start from IDLE or straight out of the final stop bit.
    assign accept = data_valid && ((state == IDLE) || (state == LAST_STOP));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            ser_en    <= 1'b0;
            data_reg  <= '0;
            par_en_r  <= 1'b0;
            par_typ_r <= 1'b0;
        end else begin
            if (accept) begin
                data_reg  <= p_data;
                par_en_r  <= par_en;
                par_typ_r <= par_typ;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state  <= START;
                        busy   <= 1'b1;
                        ser_en <= 1'b1;
                    end
                end
                START: begin
                    state <= DATA;
                end
                DATA: begin
                    if (ser_done) begin
                        ser_en <= 1'b0;
                        state  <= par_en_r ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    state <= STOP;
                end
`ifdef UART_TX_STOP2_EN
                STOP: begin
                    state <= STOP2;
                end
                STOP2: begin
                    if (accept) begin
                        state  <= START;
                        ser_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`else
                STOP: begin
                    if (accept) begin
                        state  <= START;
                        ser_en <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
`endif
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    ser_en <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        tx_out = 1'b1;
        case (state)
            START:   tx_out = 1'b0;
            DATA:    tx_out = s_data;
            PARITY:  tx_out = par_bit;
            default: tx_out = 1'b1;
        endcase
    end

endmodule
